// File: rtl/echo_mixer_pkg.sv
// Shared echo constants and the stereo sample type, common to the delay line and the mixer.
// ECHO_MIXER_CLIP_CNT_EN also adds the clip counter width.
package echo_mixer_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned WORD_W   = 2 * SAMPLE_W;
    localparam int unsigned GAIN_W   = 8;

    // Channel slices within a stereo word
    localparam int unsigned L_HI = WORD_W - 1;
    localparam int unsigned L_LO = SAMPLE_W;
    localparam int unsigned R_HI = SAMPLE_W - 1;
    localparam int unsigned R_LO = 0;

    localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

`ifdef ECHO_MIXER_CLIP_CNT_EN
    localparam int unsigned CLIP_CNT_W = 16;
`endif

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] l;
        logic signed [SAMPLE_W-1:0] r;
    } stereo_t;

endpackage

// File: rtl/echo_mixer_if.sv
// Input and output sample streams of the echo mixer; slave is the mixer side.
interface echo_mixer_if;
    import echo_mixer_pkg::*;

    logic              s_valid;
    logic              s_ready;
    stereo_t           dry;
    stereo_t           wet;
    logic [GAIN_W-1:0] gain;
    logic              mix_en;
    logic              m_valid;
    logic              m_ready;
    stereo_t           out;
    logic              clip;

    modport master (
        output s_valid, dry, wet, gain, mix_en, m_ready,
        input  s_ready, m_valid, out, clip
    );

    modport slave (
        input  s_valid, dry, wet, gain, mix_en, m_ready,
        output s_ready, m_valid, out, clip
    );

endinterface

// File: rtl/echo_chan_scale_sat.sv
// One channel of the mixer: wet scaling (registered as stage 2), then dry + wet with saturation.
module echo_chan_scale_sat
    import echo_mixer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en_i,
    input  logic signed [SAMPLE_W-1:0] dry_i,
    input  logic signed [SAMPLE_W-1:0] wet_i,
    input  logic        [GAIN_W-1:0]   gain_i,
    input  logic                       mix_en_i,
    output logic signed [SAMPLE_W-1:0] res_o_c,
    output logic                       sat_o_c
);

    localparam int unsigned PROD_W = SAMPLE_W + GAIN_W + 1;
    localparam int unsigned W_W    = SAMPLE_W + 1;
    localparam int unsigned SUM_W  = SAMPLE_W + 2;

    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'($signed(SAT_MAX));
    localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'($signed(SAT_MIN));

    logic signed [PROD_W-1:0]   prod_c;
    logic signed [W_W-1:0]      w_d;
    logic signed [W_W-1:0]      w_q;
    logic signed [SAMPLE_W-1:0] dry_q;
    logic signed [SUM_W-1:0]    sum_c;

    // Gain is unsigned, so it gets a zero sign bit; >>> floors toward minus infinity
    always_comb begin
        prod_c = PROD_W'(wet_i) * PROD_W'($signed({1'b0, gain_i}));
        w_d    = mix_en_i ? W_W'(prod_c >>> GAIN_W) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_q   <= '0;
            dry_q <= '0;
        end else if (en_i) begin
            w_q   <= w_d;
            dry_q <= dry_i;
        end
    end

    always_comb begin
        sum_c   = SUM_W'(dry_q) + SUM_W'(w_q);
        res_o_c = sum_c[SAMPLE_W-1:0];
        sat_o_c = 1'b0;
        if (sum_c > MAX_S) begin
            res_o_c = SAT_MAX;
            sat_o_c = 1'b1;
        end else if (sum_c < MIN_S) begin
            res_o_c = SAT_MIN;
            sat_o_c = 1'b1;
        end
    end

endmodule

// File: rtl/echo_mixer.sv
// Echo mixer: 3-stage dry + gain*wet pipeline with global stall and per-channel saturation.
// Define ECHO_MIXER_CLIP_CNT_EN to add the clip_clr input and clip_count output.
module echo_mixer
    import echo_mixer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
`ifdef ECHO_MIXER_CLIP_CNT_EN
    input  logic                  clip_clr,
    output logic [CLIP_CNT_W-1:0] clip_count,
`endif
    echo_mixer_if.slave           bus
);

    logic              adv_c;
    logic              v1_q;
    logic              v2_q;
    logic              m_valid_q;
    stereo_t           dry1_q;
    stereo_t           wet1_q;
    logic [GAIN_W-1:0] gain1_q;
    logic              mix1_q;
    stereo_t           out_q;
    logic              clip_q;
    logic signed [SAMPLE_W-1:0] res_l_c;
    logic signed [SAMPLE_W-1:0] res_r_c;
    logic              sat_l_c;
    logic              sat_r_c;

    // The whole pipeline advances together whenever the output slot is free or draining
    assign adv_c       = !m_valid_q || bus.m_ready;
    assign bus.s_ready = adv_c && reset_n;
    assign bus.m_valid = m_valid_q;
    assign bus.out     = out_q;
    assign bus.clip    = clip_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q    <= 1'b0;
            dry1_q  <= '0;
            wet1_q  <= '0;
            gain1_q <= '0;
            mix1_q  <= 1'b0;
            v2_q    <= 1'b0;
        end else if (adv_c) begin
            v1_q    <= bus.s_valid;
            dry1_q  <= bus.dry;
            wet1_q  <= bus.wet;
            gain1_q <= bus.gain;
            mix1_q  <= bus.mix_en;
            v2_q    <= v1_q;
        end
    end

    echo_chan_scale_sat u_chan_l (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (adv_c),
        .dry_i    (dry1_q.l),
        .wet_i    (wet1_q.l),
        .gain_i   (gain1_q),
        .mix_en_i (mix1_q),
        .res_o_c  (res_l_c),
        .sat_o_c  (sat_l_c)
    );

    echo_chan_scale_sat u_chan_r (
        .clk      (clk),
        .reset_n  (reset_n),
        .en_i     (adv_c),
        .dry_i    (dry1_q.r),
        .wet_i    (wet1_q.r),
        .gain_i   (gain1_q),
        .mix_en_i (mix1_q),
        .res_o_c  (res_r_c),
        .sat_o_c  (sat_r_c)
    );

    // Output stage only loads on a valid sample so out/clip hold through bubbles and stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q <= 1'b0;
            out_q     <= '0;
            clip_q    <= 1'b0;
        end else if (adv_c) begin
            m_valid_q <= v2_q;
            if (v2_q) begin
                out_q[L_HI:L_LO] <= res_l_c;
                out_q[R_HI:R_LO] <= res_r_c;
                clip_q           <= sat_l_c || sat_r_c;
            end
        end
    end

`ifdef ECHO_MIXER_CLIP_CNT_EN
    logic [CLIP_CNT_W-1:0] clip_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_cnt_q <= '0;
        end else if (clip_clr) begin
            clip_cnt_q <= '0;
        end else if (m_valid_q && bus.m_ready && clip_q && (clip_cnt_q != '1)) begin
            clip_cnt_q <= clip_cnt_q + CLIP_CNT_W'(1);
        end
    end

    assign clip_count = clip_cnt_q;
`endif

endmodule

// File: tb/tb_echo_mixer.sv
// Bench for echo_mixer: directed vectors with literal expectations plus an arithmetic scoreboard.
module tb_echo_mixer;
    import echo_mixer_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    echo_mixer_if bus();

`ifdef ECHO_MIXER_CLIP_CNT_EN
    logic                  clip_clr = 1'b0;
    logic [CLIP_CNT_W-1:0] clip_count;
`endif

    echo_mixer dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef ECHO_MIXER_CLIP_CNT_EN
        .clip_clr   (clip_clr),
        .clip_count (clip_count),
`endif
        .bus        (bus)
    );

    int          checks = 0;
    int          failures = 0;
    int          popped = 0;
    logic [32:0] exp_q[$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_out;
    logic        prev_clip;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: out = sat(dry + floor(wet*gain/256)) per channel, clip if any channel clamps
    function automatic logic [32:0] model(input logic [31:0] d, input logic [31:0] w,
                                          input logic [7:0] g, input logic m);
        logic [15:0] o0, o1;
        logic        sat_any;
        sat_any = 1'b0;
        o0 = '0;
        o1 = '0;
        for (int c = 0; c < 2; c++) begin
            logic signed [15:0] ds, ws;
            int p, x, s;
            if (c == 0) begin ds = d[31:16]; ws = w[31:16]; end
            else        begin ds = d[15:0];  ws = w[15:0];  end
            p = int'(ws) * int'(g);
            if (!m)          x = 0;
            else if (p >= 0) x = p / 256;
            else             x = -((-p + 255) / 256);
            s = int'(ds) + x;
            if (s > 32767)       begin s = 32767;  sat_any = 1'b1; end
            else if (s < -32768) begin s = -32768; sat_any = 1'b1; end
            if (c == 0) o0 = s[15:0];
            else        o1 = s[15:0];
        end
        return {sat_any, o0, o1};
    endfunction

    // Scoreboard and hold-stability checks, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_m_valid", bus.m_valid, 0);
            chk("rst_out", bus.out, 0);
            chk("rst_clip", bus.clip, 0);
            chk("rst_s_ready", bus.s_ready, 0);
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_m_valid", bus.m_valid, 1);
                chk("hold_out", bus.out, prev_out);
                chk("hold_clip", bus.clip, prev_clip);
            end
            if (bus.s_valid && bus.s_ready)
                exp_q.push_back(model(bus.dry, bus.wet, bus.gain, bus.mix_en));
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_extra actual=%0h expected=none at %0t", bus.out, $time);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("sb_out", bus.out, e[31:0]);
                    chk("sb_clip", bus.clip, e[32]);
                    popped++;
                end
            end
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_out  = bus.out;
            prev_clip = bus.clip;
        end
    end

    // Present one sample at an idle pipeline; returns #1 after m_valid rises
    task automatic single(input logic [31:0] d, input logic [31:0] w, input logic [7:0] g,
                          input logic m, input logic [31:0] eo, input logic ec, input string nm);
        int lat;
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.dry     = d;
        bus.wet     = w;
        bus.gain    = g;
        bus.mix_en  = m;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        lat = 1;
        while (!bus.m_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, lat, 3);
        chk({nm, "_out"}, bus.out, eo);
        chk({nm, "_clip"}, bus.clip, ec);
    endtask

    task automatic drive_vec(input int i);
        bus.dry    = {16'(i * 5000 - 17000), 16'(12000 - i * 3100)};
        bus.wet    = {16'(i * 9000 - 30000), 16'(20000 - i * 7000)};
        bus.gain   = 8'(i * 37 + 5);
        bus.mix_en = (i != 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        bus.dry     = '0;
        bus.wet     = '0;
        bus.gain    = '0;
        bus.mix_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk("idle_s_ready", bus.s_ready, 1);
        chk("idle_m_valid", bus.m_valid, 0);
        @(posedge clk); #1;

        single(32'h1000_2000, 32'h0800_F000, 8'h80, 1'b1, 32'h1400_1800, 1'b0, "basic");
        single(32'h7000_9000, 32'h7FFF_8000, 8'hFF, 1'b1, 32'h7FFF_8000, 1'b1, "sat");
        single(32'h0000_0000, 32'h0000_FFFF, 8'h01, 1'b1, 32'h0000_FFFF, 1'b0, "floor_m1");
        single(32'h1234_5678, 32'h7FFF_8000, 8'hFF, 1'b0, 32'h1234_5678, 1'b0, "passthru");
        single(32'hABCD_0123, 32'h7FFF_8000, 8'h00, 1'b1, 32'hABCD_0123, 1'b0, "gain0");
        single(32'h0000_0000, 32'h0000_FED3, 8'h40, 1'b1, 32'h0000_FFB4, 1'b0, "floor_neg");
        single(32'h7FFF_0000, 32'h0000_7FFF, 8'hFF, 1'b1, 32'h7FFF_7F7F, 1'b0, "no_carry");
        single(32'h0000_7FFF, 32'h0000_0100, 8'h80, 1'b1, 32'h0000_7FFF, 1'b1, "one_ch_sat");
        @(posedge clk); #1;

        // Back-to-back stream with a 5-cycle output stall after the first m_valid
        begin
            int idx, base, hold;
            bit seen, saw_stall;
            idx = 0; base = popped; hold = 0; seen = 0; saw_stall = 0;
            for (int cyc = 0; cyc < 60 && (popped - base) < 8; cyc++) begin
                if (bus.m_valid && !seen) begin seen = 1; hold = 5; end
                bus.m_ready = (hold == 0);
                if (hold > 0) hold--;
                if (idx < 8) begin bus.s_valid = 1'b1; drive_vec(idx); end
                else bus.s_valid = 1'b0;
                @(negedge clk);
                if (bus.s_valid && bus.s_ready) idx++;
                if (!bus.s_ready) saw_stall = 1;
                @(posedge clk); #1;
            end
            bus.s_valid = 1'b0;
            bus.m_ready = 1'b1;
            chk("bp_accepted", idx, 8);
            chk("bp_emitted", popped - base, 8);
            chk("bp_s_ready_drop", saw_stall, 1);
        end
        @(posedge clk); #1;

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.dry     = 32'h7000_9000 + 32'(i);
            bus.wet     = 32'h7FFF_8000;
            bus.gain    = 8'hFF;
            bus.mix_en  = 1'b1;
            @(posedge clk); #1;
        end
        chk("pre_rst_m_valid", bus.m_valid, 1);
        bus.s_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_m_valid", bus.m_valid, 0);
        chk("mid_rst_out", bus.out, 0);
        chk("mid_rst_clip", bus.clip, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        begin
            int stale;
            stale = 0;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                if (bus.m_valid) stale++;
            end
            chk("no_stale", stale, 0);
        end
        single(32'h0100_0200, 32'h0400_0800, 8'h40, 1'b1, 32'h0200_0400, 1'b0, "fresh");
        @(posedge clk); #1;

`ifdef ECHO_MIXER_CLIP_CNT_EN
        clip_clr = 1'b1;
        @(posedge clk); #1;
        clip_clr = 1'b0;
        chk("cnt_cleared", clip_count, 0);
        for (int i = 0; i < 3; i++)
            single(32'h7000_9000, 32'h7FFF_8000, 8'hFF, 1'b1, 32'h7FFF_8000, 1'b1, "cnt_sat");
        @(posedge clk); #1;
        chk("cnt_three", clip_count, 3);
        single(32'h7000_9000, 32'h7FFF_8000, 8'hFF, 1'b1, 32'h7FFF_8000, 1'b1, "cnt_sat4");
        clip_clr = 1'b1;
        @(posedge clk); #1;
        clip_clr = 1'b0;
        chk("cnt_clr_wins", clip_count, 0);
`endif

        repeat (5) @(posedge clk);
        #1 chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
